coin_acceptor: RTL and testbench

Coin-sensor front end that produces the 2-bit coin code consumed by the vending FSM's `in` port.

- Synchronizes and debounces two raw coin sensors (5-unit, 10-unit) and rejects ambiguous or overflowing insertions.
- Buffers accepted coins in a 4-entry FIFO.
- Replays each buffered coin as a single-cycle code, with guaranteed idle spacing, so the FSM sees every coin exactly once.

---
 rtl/coin_acceptor.sv | 275 +++++++++++++++++++++++++++
 tb/tb_coin_acceptor.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// coin_acceptor: coin-sensor front end for the vending FSM.
//   raw sensors -> 2-FF synchronizers -> per-sensor debouncers -> rising-edge
//   classifier -> 4-entry coin FIFO -> IDLE/EMIT/GAP replay FSM -> `coin`.
// Optional build macro COIN_ACCEPTOR_STATS_EN adds the 8-bit `total` output,
// a modulo-256 running sum of emitted coin values.
module coin_acceptor #(
  parameter int DEBOUNCE = 4,  // consecutive differing samples to flip a level (>=2)
  parameter int GAP      = 1   // forced idle cycles after every emitted code (>=1)
) (
  input  logic       clk,
  input  logic       rst,        // asynchronous, active low
  input  logic       sense_5,
  input  logic       sense_10,
  output logic [1:0] coin,
  output logic       reject,
  output logic [2:0] fifo_count,
`ifdef COIN_ACCEPTOR_STATS_EN
  output logic [7:0] total,
`endif
  output logic       busy
);

  localparam int DB_W  = (DEBOUNCE < 2) ? 2 : $clog2(DEBOUNCE + 1);
  localparam int GAP_W = (GAP < 1) ? 1 : $clog2(GAP + 1);

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_5    = 2'b01;
  localparam logic [1:0] CODE_10   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Sensor front end: bit 0 is the 5-unit sensor, bit 1 the 10-unit one.
  // ---------------------------------------------------------------------
  logic [1:0] sense_raw;
  logic [1:0] rise;

  assign sense_raw = {sense_10, sense_5};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sensor
      logic            sync1_q;
      logic            sync2_q;
      logic            level_q;
      logic            level_d;
      logic            level_prev_q;
      logic [DB_W-1:0] cnt_q;
      logic [DB_W-1:0] cnt_d;

      // Two-stage synchronizer for the asynchronous raw sensor.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
        end else begin
          sync1_q <= sense_raw[gi];
          sync2_q <= sync1_q;
        end
      end

      // Debounce: count consecutive samples disagreeing with the level; flip
      // on the DEBOUNCE-th one. An agreeing sample restarts the count.
      always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
          if (cnt_q == DB_W'(DEBOUNCE - 1)) begin
            level_d = ~level_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Debounced level, its one-cycle-old copy, and the disagreement counter.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          level_q      <= 1'b0;
          level_prev_q <= 1'b0;
          cnt_q        <= '0;
        end else begin
          level_q      <= level_d;
          level_prev_q <= level_q;
          cnt_q        <= cnt_d;
        end
      end

      // A coin event is a debounced rising edge; falling edges are ignored.
      assign rise[gi] = level_q & ~level_prev_q;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Classification and FIFO control
  // ---------------------------------------------------------------------
  state_t     state_q;
  state_t     state_d;
  logic [2:0] count_q;
  logic [2:0] count_d;
  logic [1:0] wr_ptr_q;
  logic [1:0] wr_ptr_d;
  logic [1:0] rd_ptr_q;
  logic [1:0] rd_ptr_d;
  logic [1:0] mem_q [4];
  logic [1:0] head;

  logic       push_req;
  logic [1:0] push_code;
  logic       both_rise;
  logic       full;
  logic       pop;
  logic       push;
  logic       reject_q;
  logic       reject_d;

  // Decide what a same-cycle pair of sensor events means.
  always_comb begin
    push_req  = 1'b0;
    push_code = CODE_NONE;
    both_rise = 1'b0;
    case (rise)
      2'b01: begin
        push_req  = 1'b1;
        push_code = CODE_5;
      end
      2'b10: begin
        push_req  = 1'b1;
        push_code = CODE_10;
      end
      2'b11: both_rise = 1'b1;
      default: ;
    endcase
  end

  // The replay FSM pops whenever it is idle and something is buffered; a pop
  // frees a slot in the same cycle, so a push onto a full FIFO still lands.
  assign full = (count_q == 3'd4);
  assign pop  = (state_q == S_IDLE) && (count_q != 3'd0);
  assign push = push_req && (!full || pop);
  assign head = mem_q[rd_ptr_q];

  // Ambiguous (both sensors) or overflowing coins are handed back.
  always_comb begin
    reject_d = both_rise || (push_req && full && !pop);
  end

  // Pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: ;
    endcase
  end

  // FIFO control registers and the reject pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      reject_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      reject_q <= reject_d;
    end
  end

  // Coin storage; contents are don't-care while the count says empty, so
  // the array carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_code;
    end
  end

  // ---------------------------------------------------------------------
  // Replay FSM: IDLE pops and loads `coin`, EMIT shows it for one cycle,
  // GAP forces GAP idle cycles before the next pop is allowed.
  // ---------------------------------------------------------------------
  logic [GAP_W-1:0] gap_cnt_q;
  logic [GAP_W-1:0] gap_cnt_d;
  logic [1:0]       coin_q;
  logic [1:0]       coin_d;

  // Next state, gap counter and the code to show next cycle.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    coin_d    = CODE_NONE;
    case (state_q)
      S_IDLE: begin
        if (count_q != 3'd0) begin
          coin_d  = head;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        state_d   = S_GAP;
        gap_cnt_d = GAP_W'(GAP);
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, gap counter and registered coin code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      gap_cnt_q <= '0;
      coin_q    <= CODE_NONE;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      coin_q    <= coin_d;
    end
  end

`ifdef COIN_ACCEPTOR_STATS_EN
  logic [7:0] total_q;
  logic [7:0] total_d;

  // Add the coin value at the edge that enters EMIT, so `total` already
  // includes the coin while it is being shown.
  always_comb begin
    total_d = total_q;
    case (coin_d)
      CODE_5:  total_d = total_q + 8'd5;
      CODE_10: total_d = total_q + 8'd10;
      default: ;
    endcase
  end

  // Running total register, wraps modulo 256.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_q <= 8'd0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total = total_q;
`endif

  assign coin       = coin_q;
  assign reject     = reject_q;
  assign fifo_count = count_q;
  assign busy       = (count_q != 3'd0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: two coin_acceptor instances (GAP=1 and GAP=30) share the
// same sensors; a behavioural model predicts every output cycle by cycle.
module tb_coin_acceptor;
  localparam int DB    = 4;
  localparam int GAP_A = 1;
  localparam int GAP_B = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s5;
  logic       s10;
  logic [1:0] coin_a, coin_b;
  logic       rej_a, rej_b;
  logic [2:0] cnt_a, cnt_b;
  logic       busy_a, busy_b;
`ifdef COIN_ACCEPTOR_STATS_EN
  logic [7:0] total_a, total_b;
`endif

  coin_acceptor #(.DEBOUNCE(DB), .GAP(GAP_A)) dut_a (
    .clk(clk), .rst(rst), .sense_5(s5), .sense_10(s10),
    .coin(coin_a), .reject(rej_a), .fifo_count(cnt_a),
`ifdef COIN_ACCEPTOR_STATS_EN
    .total(total_a),
`endif
    .busy(busy_a));

  coin_acceptor #(.DEBOUNCE(DB), .GAP(GAP_B)) dut_b (
    .clk(clk), .rst(rst), .sense_5(s5), .sense_10(s10),
    .coin(coin_b), .reject(rej_b), .fifo_count(cnt_b),
`ifdef COIN_ACCEPTOR_STATS_EN
    .total(total_b),
`endif
    .busy(busy_b));

  int n_eval = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  int         edge_n;
  bit         lvl    [2];
  bit         rise_m [2];
  bit         dl     [2][$];   // raw sample -> debouncer input, two edges late
  bit         win    [2][$];   // most recent samples since the last level change
  logic [1:0] mf     [2][$];   // buffered coin codes per instance
  int         last_pop [2];
  int         gapv   [2];
  logic [1:0] e_coin [2];
  logic       e_rej  [2];
  int         e_cnt  [2];
  logic       e_busy [2];
  int         e_total[2];

  // trackers for directed checks
  int         pulses_a, pulses_b, rejs_a, rejs_b, peak_b, first_a;
  logic [1:0] seq_b [$];

  task automatic model_reset();
    edge_n = 0;
    for (int i = 0; i < 2; i++) begin
      lvl[i] = 1'b0;
      rise_m[i] = 1'b0;
      dl[i].delete();
      dl[i].push_back(1'b0);
      dl[i].push_back(1'b0);
      win[i].delete();
      mf[i].delete();
      last_pop[i] = -1000;
      e_coin[i] = 2'b00;
      e_rej[i] = 1'b0;
      e_cnt[i] = 0;
      e_busy[i] = 1'b0;
      e_total[i] = 0;
    end
  endtask

  task automatic model_edge(input bit r5, input bit r10);
    bit r [2];
    int sz;
    bit popped;
    bit smp;
    bit all_diff;
    r[0] = r5;
    r[1] = r10;
    edge_n++;
    // Coin events found at the previous edge meet the FIFO now; the replay
    // side may take the head once GAP+2 edges have passed since its last pop.
    for (int i = 0; i < 2; i++) begin
      sz = mf[i].size();
      popped = (sz > 0) && (edge_n - last_pop[i] >= gapv[i] + 2);
      e_coin[i] = 2'b00;
      e_rej[i] = 1'b0;
      if (popped) begin
        e_coin[i] = mf[i].pop_front();
        last_pop[i] = edge_n;
        e_total[i] = (e_total[i] + ((e_coin[i] == 2'b01) ? 5 : 10)) % 256;
      end
      if (rise_m[0] && rise_m[1]) begin
        e_rej[i] = 1'b1;
      end else if (rise_m[0] || rise_m[1]) begin
        if (sz < 4 || popped) mf[i].push_back(rise_m[0] ? 2'b01 : 2'b10);
        else e_rej[i] = 1'b1;
      end
      e_cnt[i] = mf[i].size();
      e_busy[i] = (mf[i].size() > 0) || (edge_n - last_pop[i] <= gapv[i]);
    end
    // Debounced level flips once the last DB samples all disagree with it.
    for (int s = 0; s < 2; s++) begin
      dl[s].push_back(r[s]);
      smp = dl[s].pop_front();
      win[s].push_back(smp);
      if (win[s].size() > DB) void'(win[s].pop_front());
      rise_m[s] = 1'b0;
      all_diff = (win[s].size() == DB);
      for (int k = 0; k < win[s].size(); k++) if (win[s][k] == lvl[s]) all_diff = 1'b0;
      if (all_diff) begin
        lvl[s] = ~lvl[s];
        rise_m[s] = lvl[s];
        win[s].delete();
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_eval++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all();
    chk("coin_a",  32'(coin_a),  32'(e_coin[0]));
    chk("rej_a",   32'(rej_a),   32'(e_rej[0]));
    chk("count_a", 32'(cnt_a),   32'(e_cnt[0]));
    chk("busy_a",  32'(busy_a),  32'(e_busy[0]));
    chk("coin_b",  32'(coin_b),  32'(e_coin[1]));
    chk("rej_b",   32'(rej_b),   32'(e_rej[1]));
    chk("count_b", 32'(cnt_b),   32'(e_cnt[1]));
    chk("busy_b",  32'(busy_b),  32'(e_busy[1]));
`ifdef COIN_ACCEPTOR_STATS_EN
    chk("total_a", 32'(total_a), 32'(e_total[0]));
    chk("total_b", 32'(total_b), 32'(e_total[1]));
`endif
  endtask

  task automatic clear_trk();
    pulses_a = 0; pulses_b = 0; rejs_a = 0; rejs_b = 0; peak_b = 0; first_a = -1;
    seq_b.delete();
  endtask

  // One clock: drive at the falling edge, model at the rising edge, sample
  // 1 time unit later, finish back on a falling edge.
  task automatic cycle(input bit v5, input bit v10);
    s5 = v5;
    s10 = v10;
    @(posedge clk);
    if (rst) model_edge(v5, v10);
    #1;
    check_all();
    if (coin_a != 2'b00) begin
      pulses_a++;
      if (first_a < 0) first_a = edge_n;
    end
    if (coin_b != 2'b00) begin
      pulses_b++;
      seq_b.push_back(coin_b);
    end
    if (rej_a) rejs_a++;
    if (rej_b) rejs_b++;
    if (int'(cnt_b) > peak_b) peak_b = int'(cnt_b);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0);
  endtask

  // Coins alternating 5/10, one every 6 cycles, each held high 4 cycles.
  task automatic send_coins(input int n);
    for (int c = 0; c < n; c++) begin
      for (int h = 0; h < 6; h++) begin
        if (c % 2 == 0) cycle(h < 4, 1'b0);
        else            cycle(1'b0, h < 4);
      end
    end
  endtask

  task automatic reset_pulse(input int hold);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    for (int k = 0; k < hold; k++) cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    rst = 1'b1;
  endtask

  int e0;
  bit found;
  bit v5, v10;
  int hold;

  initial begin
    gapv[0] = GAP_A;
    gapv[1] = GAP_B;
    rst = 1'b0;
    s5 = 1'b0;
    s10 = 1'b0;
    model_reset();
    clear_trk();
    @(negedge clk);

    // Reset held with sensors toggling: every output stays quiet.
    for (int k = 0; k < 10; k++) cycle(k % 2 == 0, k % 3 == 0);
    chk("rst_hold_pulses", 32'(pulses_a + pulses_b + rejs_a + rejs_b), 32'd0);
    cycle(1'b0, 1'b0);
    rst = 1'b1;
    idle(6);

    // Single 5-unit coin: code appears 7 edges after the first high sample.
    clear_trk();
    e0 = edge_n + 1;
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0);
    idle(20);
    chk("lat5_edges", 32'(first_a - e0), 32'd7);
    chk("pulses5_a", 32'(pulses_a), 32'd1);
    chk("pulses5_b", 32'(pulses_b), 32'd1);
    chk("cnt5_end", 32'(cnt_a), 32'd0);

    // 10-unit sensor: a 3-cycle glitch is ignored, a 6-cycle press counts.
    clear_trk();
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1);
    idle(12);
    chk("glitch10_pulses", 32'(pulses_a + rejs_a), 32'd0);
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1);
    idle(15);
    chk("coin10_pulses", 32'(pulses_a), 32'd1);
    chk("coin10_code", 32'(seq_b.size() == 1 ? seq_b[0] : 2'b11), 32'd2);

    // Both sensors together: one reject, nothing buffered.
    clear_trk();
    for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1);
    idle(15);
    chk("both_rej", 32'(rejs_a), 32'd1);
    chk("both_coin", 32'(pulses_a + pulses_b), 32'd0);
    chk("both_peak", 32'(peak_b), 32'd0);

    // Six coins into the GAP=30 instance: FIFO fills to 4, sixth is rejected.
    clear_trk();
    send_coins(6);
    idle(180);
    chk("burst_peak_b", 32'(peak_b), 32'd4);
    chk("burst_rej_b", 32'(rejs_b), 32'd1);
    chk("burst_rej_a", 32'(rejs_a), 32'd0);
    chk("burst_pulses_a", 32'(pulses_a), 32'd6);
    chk("burst_pulses_b", 32'(pulses_b), 32'd5);
    for (int k = 0; k < 5; k++)
      chk("burst_order_b", 32'(k < seq_b.size() ? seq_b[k] : 2'b11), (k % 2 == 0) ? 32'd1 : 32'd2);

    // Reset during EMIT with three coins still queued in the GAP=30 instance.
    clear_trk();
    send_coins(5);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      cycle(1'b0, 1'b0);
      if (coin_b != 2'b00 && cnt_b == 3'd3) found = 1'b1;
    end
    chk("emit_with_3_found", 32'(found), 32'd1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_emit_coin_b", 32'(coin_b), 32'd0);
    chk("rst_emit_cnt_b", 32'(cnt_b), 32'd0);
    @(negedge clk);
    idle(3);
    rst = 1'b1;
    clear_trk();
    idle(80);
    chk("post_rst_pulses", 32'(pulses_a + pulses_b), 32'd0);

    // Randomized sensor activity with occasional asynchronous resets.
    for (int k = 0; k < 900; ) begin
      v5 = ($urandom_range(0, 2) == 0);
      v10 = ($urandom_range(0, 2) == 0);
      hold = $urandom_range(1, 9);
      for (int h = 0; h < hold; h++) begin
        cycle(v5, v10);
        k++;
      end
      if ($urandom_range(0, 59) == 0) reset_pulse($urandom_range(1, 3));
    end
    idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
